fpm_rr_sched: RTL and testbench
===============================

Name: fpm_rr_sched

Overview:
- Shares one half-precision floating-point multiply datapath between NREQ requesters.
- Round-robin arbitration; two-stage valid/ready pipeline: operand capture stage, then multiply/result stage.
- Returns each product tagged with the requester index.
- Sits between client engines and the single fp16 multiplier instance.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, $clog2(NREQ), width of the requester tag

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept (one-hot or zero)
req_a  input  NREQ*16  operand A per requester, fp16 {sign, exp[4:0], man[9:0]}, requester i at [16i+15:16i]
req_b  input  NREQ*16  operand B per requester, same packing
rsp_valid  output  1  result valid
rsp_ready  input  1  downstream accepts result
rsp_id  output  IDW  index of the requester that owns rsp_result
rsp_result  output  16  fp16 product
busy  output  1  high while any pipeline stage holds an entry

Behaviour:
- Interface:
  - One clock, clk. Reset rst_n is synchronous and active-low.
  - All state is cleared on a clk edge where rst_n=0.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_result=0, busy=0.
  - req_ready=0; round-robin pointer=0; both stage valids=0.
- Handshakes:
  - Transfer occurs when valid&&ready are both high.
  - A requester holds req_valid and its operands stable until its req_ready is seen.
  - req_ready may depend combinationally on req_valid, never the reverse.
  - Downstream: rsp_* holds stable while rsp_valid && !rsp_ready.
- Arbitration:
  - Grant goes to the first valid requester at or after the pointer, searching upward with wrap at NREQ-1 -> 0.
  - req_ready[i] = grant[i] && s1_accept.
  - s1_accept = !s1_valid || s1_advance.
  - After a transfer to requester g, the pointer becomes (g+1) mod NREQ.
  - Without a transfer, the pointer is unchanged.
- Stage 1 (S1): registers a, b, id.
- Stage 2 (S2): registers {result, id}, which drive rsp_* directly.
  - s1_advance = s1_valid && (!s2_valid || rsp_ready).
- Latency and throughput:
  - rsp_valid rises 2 cycles after the request transfer edge.
  - Sustained throughput is 1 result/clk while rsp_ready=1.
  - A full stall with both stages occupied holds both entries; no loss, no duplication.
- Simultaneous events: S2 drain and S1 advance occur in the same cycle; S1 refill from arbitration occurs in the same cycle.
- Multiply arithmetic, combinational between S1 and S2:
  - sign = sa^sb.
  - Significands are {1, man} (11 bits); p = 22-bit product.
  - exp = ea + eb - 15, 5-bit modular.
  - If p[21]: man = p[20:11], exp = exp+1.
  - Otherwise: man = p[19:10].
  - Truncation, no rounding.
  - No zero, subnormal, inf or NaN handling; exponent over/underflow wraps modulo 32.
- busy = s1_valid || s2_valid.
- Reset mid-operation: in-flight entries are discarded; no rsp_valid appears for them after reset.

Optional Feature:
- Macro: FPM_RR_SCHED_PRIO0_EN.
- When defined: requester 0 has strict priority and is granted whenever req_valid[0]=1.
  - The remaining requesters rotate round-robin among themselves.
  - The pointer ranges over 1..NREQ-1 and is not updated on grants to requester 0.
- When undefined: pure round-robin over all NREQ requesters as above.

Decomposition:
- Shared package fpm_pkg:
  - fp16_t packed struct {sign, exp[4:0], man[9:0]}.
  - FP16_BIAS=5'd15, FP16_EXP_W=5, FP16_MAN_W=10.
- Natural sub-module fpm_core: combinational fp16 multiply exactly as specified.
  - The scheduler instantiates it once between S1 and S2.
- Arbiter stays inline in fpm_rr_sched.

Test Plan:
- Single request: requester 2 sends a=0x3E00, b=0x3E00, rsp_ready=1 -> req_ready[2] high on the same cycle; 2 clks later rsp_valid=1, rsp_result=0x4080, rsp_id=2.
- Sign/exponent: a=0x4000, b=0xC200 -> rsp_result=0xC600. 0x3C00*0x3C00 -> 0x3C00.
- Fairness: all 4 requesters valid continuously with pointer=0, rsp_ready=1 -> grant order 0,1,2,3,0,1 and one result per clk with matching rsp_id sequence.
- Backpressure: rsp_ready=0 for 5 clks with requests pending:
  - After 2 transfers, all req_ready stay 0 and rsp_* is stable.
  - On release, the 2 held results drain in order, then arbitration resumes.
- Reset mid-flight: rst_n=0 for 1 clk with both stages full -> next cycle rsp_valid=0, busy=0, pointer=0; no stale result is ever emitted.
- FPM_RR_SCHED_PRIO0_EN defined, requesters 0 and 1 always valid -> requester 0 granted every cycle and requester 1 never until req_valid[0] drops.

Source files
------------

// File: rtl/fpm_pkg.sv
// Shared fp16 definitions for the shared multiplier scheduler and its datapath.
package fpm_pkg;

    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;
    localparam logic [FP16_EXP_W-1:0] FP16_BIAS = 5'd15;

    // Half-precision layout {sign, exp[4:0], man[9:0]}
    typedef struct packed {
        logic                  sign;
        logic [FP16_EXP_W-1:0] exp;
        logic [FP16_MAN_W-1:0] man;
    } fp16_t;

endpackage

// File: rtl/fpm_core.sv
// Combinational fp16 multiply: truncating, no special-value handling,
// exponent wraps modulo 32.
module fpm_core
    import fpm_pkg::*;
(
    input  fp16_t i_a,
    input  fp16_t i_b,
    output fp16_t o_p
);

    logic [21:0]           w_prod;
    logic [FP16_EXP_W-1:0] w_exp_sum;

    // Significand product, biased exponent sum and one-bit normalisation
    always_comb begin
        o_p       = '0;
        w_prod    = 22'({1'b1, i_a.man}) * 22'({1'b1, i_b.man});
        w_exp_sum = i_a.exp + i_b.exp - FP16_BIAS;
        o_p.sign  = i_a.sign ^ i_b.sign;
        if (w_prod[21]) begin
            o_p.man = w_prod[20:11];
            o_p.exp = w_exp_sum + 5'd1;
        end else begin
            o_p.man = w_prod[19:10];
            o_p.exp = w_exp_sum;
        end
    end

endmodule

// File: rtl/fpm_rr_sched.sv
// Round-robin scheduler sharing one fp16 multiplier between NREQ requesters.
// Two pipeline stages: S1 captures operands and tag, S2 holds the tagged
// product and drives rsp_* directly.
// Optional macro FPM_RR_SCHED_PRIO0_EN: requester 0 gets strict priority and
// the round-robin pointer rotates over requesters 1..NREQ-1 only.
//
// Handshake semantics (both sides): a beat transfers on a rising clk edge
// where valid && ready are both high. Producers hold valid and payload stable
// until ready is seen; ready may depend combinationally on valid, never the
// reverse. rsp_* is held stable while rsp_valid && !rsp_ready.
module fpm_rr_sched
    import fpm_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*16-1:0] req_a,
    input  logic [NREQ*16-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [15:0]        rsp_result,
    output logic               busy
);

`ifdef FPM_RR_SCHED_PRIO0_EN
    // Requester 0 is outside the rotation, so the pointer starts at 1
    localparam logic [IDW-1:0] PTR_RST = IDW'(1);
`else
    localparam logic [IDW-1:0] PTR_RST = '0;
`endif

    logic [IDW-1:0] r_ptr;
    logic           r_s1_valid;
    fp16_t          r_s1_a;
    fp16_t          r_s1_b;
    logic [IDW-1:0] r_s1_id;
    logic           r_s2_valid;
    fp16_t          r_s2_result;
    logic [IDW-1:0] r_s2_id;

    logic           w_found;
    logic [IDW-1:0] w_gid;
    logic [IDW-1:0] w_ptr_nxt;
    logic           w_s1_advance;
    logic           w_s1_accept;
    logic           w_xfer;
    fp16_t          w_product;

    // Grant search: first valid requester at or after the pointer, wrapping
    always_comb begin : arb
        logic [IDW:0] v_sum;
        w_found = 1'b0;
        w_gid   = '0;
        v_sum   = '0;
`ifdef FPM_RR_SCHED_PRIO0_EN
        if (req_valid[0]) begin
            w_found = 1'b1;
        end else begin
            for (int k = 0; k < NREQ - 1; k++) begin
                v_sum = {1'b0, r_ptr} + (IDW+1)'(k);
                if (v_sum >= (IDW+1)'(NREQ)) v_sum = v_sum - (IDW+1)'(NREQ - 1);
                if (!w_found && req_valid[v_sum[IDW-1:0]]) begin
                    w_found = 1'b1;
                    w_gid   = v_sum[IDW-1:0];
                end
            end
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            v_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (v_sum >= (IDW+1)'(NREQ)) v_sum = v_sum - (IDW+1)'(NREQ);
            if (!w_found && req_valid[v_sum[IDW-1:0]]) begin
                w_found = 1'b1;
                w_gid   = v_sum[IDW-1:0];
            end
        end
`endif
    end

    // Pointer value to adopt after a transfer to the granted requester
    always_comb begin
`ifdef FPM_RR_SCHED_PRIO0_EN
        w_ptr_nxt = r_ptr;
        if (w_gid != '0) begin
            w_ptr_nxt = (w_gid == IDW'(NREQ - 1)) ? IDW'(1) : w_gid + IDW'(1);
        end
`else
        w_ptr_nxt = (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + IDW'(1);
`endif
    end

    // Pipeline flow control and one-hot accept towards the requesters
    always_comb begin
        w_s1_advance = r_s1_valid && (!r_s2_valid || rsp_ready);
        w_s1_accept  = !r_s1_valid || w_s1_advance;
        w_xfer       = w_found && w_s1_accept;
        req_ready    = '0;
        if (w_xfer) req_ready[w_gid] = 1'b1;
    end

    fpm_core u_core (
        .i_a (r_s1_a),
        .i_b (r_s1_b),
        .o_p (w_product)
    );

    // Round-robin pointer: moves only on a transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= PTR_RST;
        end else if (w_xfer) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Stage 1: capture operands and tag of the granted requester
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_id    <= '0;
        end else if (w_s1_accept) begin
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_s1_a  <= req_a[16*w_gid +: 16];
                r_s1_b  <= req_b[16*w_gid +: 16];
                r_s1_id <= w_gid;
            end
        end
    end

    // Stage 2: register the product; drains and refills in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_id     <= '0;
        end else if (w_s1_advance) begin
            r_s2_valid  <= 1'b1;
            r_s2_result <= w_product;
            r_s2_id     <= r_s1_id;
        end else if (rsp_ready) begin
            r_s2_valid  <= 1'b0;
        end
    end

    assign rsp_valid  = r_s2_valid;
    assign rsp_id     = r_s2_id;
    assign rsp_result = r_s2_result;
    assign busy       = r_s1_valid || r_s2_valid;

endmodule

// File: tb/tb_fpm_rr_sched.sv
// Bench for fpm_rr_sched: directed scenarios plus randomized traffic checked
// against a transaction-level model (in-flight queue with ages, arithmetic
// reference multiply). Honours FPM_RR_SCHED_PRIO0_EN like the design.
module tb_fpm_rr_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = IDW + 16;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*16-1:0] req_a;
    logic [NREQ*16-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [15:0]        rsp_result;
    logic               busy;

    fpm_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected {id, result} in order, with edges since transfer
    logic [W-1:0] exp_q[$];
    int           age_q[$];
    int           m_ptr;

    // Requester state and traffic knobs
    logic [NREQ-1:0] v_r;
    logic [15:0]     a_r [NREQ];
    logic [15:0]     b_r [NREQ];
    bit              keep_on [NREQ];
    int              rand_pct;
    int              rsp_ready_pct;
    int              last_g;

    // Logs of grants and of results taken by the downstream
    int              grant_log[$];
    logic [15:0]     res_log[$];
    logic [IDW-1:0]  id_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference fp16 multiply from the arithmetic rules
    function automatic logic [15:0] fp_mul_ref(input logic [15:0] a, input logic [15:0] b);
        int sig;
        int e;
        int man;
        sig = (1024 + int'(a[9:0])) * (1024 + int'(b[9:0]));
        e   = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (sig >= (1 << 21)) begin
            e++;
            man = (sig >> 11) % 1024;
        end else begin
            man = (sig >> 10) % 1024;
        end
        e = e & 31;
        return {a[15] ^ b[15], e[4:0], man[9:0]};
    endfunction

    function automatic int model_grant();
        int i;
`ifdef FPM_RR_SCHED_PRIO0_EN
        if (v_r[0]) return 0;
        for (int k = 0; k < NREQ - 1; k++) begin
            i = 1 + ((m_ptr - 1 + k) % (NREQ - 1));
            if (v_r[i]) return i;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            i = (m_ptr + k) % NREQ;
            if (v_r[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic int ptr_reset_value();
`ifdef FPM_RR_SCHED_PRIO0_EN
        return 1;
`else
        return 0;
`endif
    endfunction

    // Driver: apply requester state and downstream ready to the DUT
    task automatic apply();
        req_valid = v_r;
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = a_r[i];
            req_b[16*i +: 16] = b_r[i];
        end
    endtask

    task automatic raise(input int i);
        v_r[i] = 1'b1;
        a_r[i] = 16'($urandom);
        b_r[i] = 16'($urandom);
    endtask

    // Driver: requester reaction after an edge, then new downstream ready
    task automatic drive_next();
        for (int i = 0; i < NREQ; i++) begin
            if (last_g == i) begin
                if (keep_on[i]) raise(i);
                else v_r[i] = 1'b0;
            end else if (!v_r[i] && $urandom_range(99) < rand_pct) begin
                raise(i);
            end
        end
        rsp_ready = ($urandom_range(99) < rsp_ready_pct);
        apply();
    endtask

    // One clock: compare outputs against the model, advance the model
    task automatic step();
        int              g;
        int              n;
        bit              fv;
        bit              acc;
        logic [NREQ-1:0] er;
        logic [W-1:0]    fr;
        g   = model_grant();
        n   = exp_q.size();
        fv  = (n > 0) && (age_q[0] >= 2);
        acc = (n < 2) || (fv && rsp_ready);
        er  = '0;
        if (g >= 0 && acc) er[g] = 1'b1;
        #1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("busy", 32'(busy), 32'(n > 0));
        chk("rsp_valid", 32'(rsp_valid), 32'(fv));
        if (fv) begin
            fr = exp_q[0];
            chk("rsp_id", 32'(rsp_id), 32'(fr[W-1:16]));
            chk("rsp_result", 32'(rsp_result), 32'(fr[15:0]));
        end
        if (fv && rsp_ready) begin
            void'(exp_q.pop_front());
            void'(age_q.pop_front());
            res_log.push_back(rsp_result);
            id_log.push_back(rsp_id);
        end
        last_g = -1;
        if (er != '0) begin
            last_g = g;
            exp_q.push_back({IDW'(g), fp_mul_ref(a_r[g], b_r[g])});
            age_q.push_back(0);
            grant_log.push_back(g);
`ifdef FPM_RR_SCHED_PRIO0_EN
            if (g != 0) m_ptr = (g == NREQ - 1) ? 1 : g + 1;
`else
            m_ptr = (g + 1) % NREQ;
`endif
        end
        foreach (age_q[i]) age_q[i]++;
        @(posedge clk);
        @(negedge clk);
        drive_next();
    endtask

    task automatic reset_dut(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        v_r   = '0;
        apply();
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        age_q.delete();
        m_ptr  = ptr_reset_value();
        last_g = -1;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        res_log.delete();
        id_log.delete();
    endtask

    task automatic drain();
        int guard;
        rand_pct      = 0;
        rsp_ready_pct = 100;
        rsp_ready     = 1'b1;
        for (int i = 0; i < NREQ; i++) keep_on[i] = 1'b0;
        guard = 0;
        while ((exp_q.size() > 0 || v_r != '0) && guard < 60) begin
            step();
            guard++;
        end
        chk("drain_timeout", 32'(exp_q.size() == 0 && v_r == '0), 32'd1);
    endtask

    task automatic send_one(input int id, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] expv, input string tag);
        int guard;
        clear_logs();
        v_r[id] = 1'b1;
        a_r[id] = a;
        b_r[id] = b;
        apply();
        guard = 0;
        while (res_log.size() == 0 && guard < 10) begin
            step();
            guard++;
        end
        chk({tag, "_timeout"}, 32'(res_log.size()), 32'd1);
        if (res_log.size() == 1) begin
            chk({tag, "_result"}, 32'(res_log[0]), 32'(expv));
            chk({tag, "_id"}, 32'(id_log[0]), 32'(id));
            chk({tag, "_latency"}, 32'(guard), 32'd3);
        end
    endtask

    initial begin
        int n_xfer;
        rst_n         = 1'b0;
        v_r           = '0;
        rsp_ready     = 1'b1;
        rsp_ready_pct = 100;
        rand_pct      = 0;
        last_g        = -1;
        for (int i = 0; i < NREQ; i++) begin
            a_r[i]     = '0;
            b_r[i]     = '0;
            keep_on[i] = 1'b0;
        end
        apply();

        // Reset values
        reset_dut(2);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);

        // Single requests: ready same cycle, result two cycles later
        send_one(2, 16'h3E00, 16'h3E00, 16'h4080, "one_1p5sq");
        send_one(1, 16'h4000, 16'hC200, 16'hC600, "one_signexp");
        send_one(3, 16'h3C00, 16'h3C00, 16'h3C00, "one_unity");
        drain();

`ifndef FPM_RR_SCHED_PRIO0_EN
        // Fairness from pointer 0 with all requesters streaming
        clear_logs();
        for (int i = 0; i < NREQ; i++) begin
            keep_on[i] = 1'b1;
            raise(i);
        end
        apply();
        repeat (8) step();
        begin
            int order [6];
            order = '{0, 1, 2, 3, 0, 1};
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("fair_grant%0d", k), 32'(grant_log[k]), 32'(order[k]));
                chk($sformatf("fair_rspid%0d", k), 32'(id_log[k]), 32'(order[k]));
            end
        end
        drain();
`else
        // Strict priority of requester 0 over requester 1
        clear_logs();
        keep_on[0] = 1'b1;
        keep_on[1] = 1'b1;
        raise(0);
        raise(1);
        apply();
        repeat (6) step();
        chk("prio_grants", 32'(grant_log.size()), 32'd6);
        foreach (grant_log[k]) chk($sformatf("prio_g%0d", k), 32'(grant_log[k]), 32'd0);
        keep_on[0] = 1'b0;
        repeat (4) step();
        chk("prio_r1_after_drop", 32'(grant_log[grant_log.size()-1]), 32'd1);
        drain();
`endif

        // Backpressure: five stalled cycles from empty, then release
        clear_logs();
        rsp_ready_pct = 0;
        rsp_ready     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            keep_on[i] = 1'b1;
            raise(i);
        end
        apply();
        repeat (5) step();
        n_xfer = grant_log.size();
        chk("stall_xfers", 32'(n_xfer), 32'd2);
        chk("stall_no_out", 32'(res_log.size()), 32'd0);
        rsp_ready_pct = 100;
        rsp_ready     = 1'b1;
        repeat (4) step();
        if (res_log.size() >= 2 && n_xfer == 2) begin
            chk("stall_drain0", 32'(id_log[0]), 32'(grant_log[0]));
            chk("stall_drain1", 32'(id_log[1]), 32'(grant_log[1]));
        end else begin
            chk("stall_drain_count", 32'(res_log.size()), 32'd2);
        end

        // Reset with both stages occupied: nothing stale afterwards
        chk("midrst_busy_before", 32'(busy), 32'd1);
        for (int i = 0; i < NREQ; i++) keep_on[i] = 1'b0;
        reset_dut(1);
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        clear_logs();
        raise(1);
        raise(2);
        raise(3);
        apply();
        repeat (6) step();
        chk("midrst_first_grant", 32'(grant_log[0]), 32'd1);
        drain();

        // Randomized traffic with random backpressure
        rand_pct      = 40;
        rsp_ready_pct = 70;
        repeat (400) step();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
